// File: rtl/count_job_sequencer.sv
// count_job_sequencer: buffers words in a small FIFO and issues them one at a
// time to the max-consecutive-ones counter, returning each tagged result on a
// valid/ready output. Only one job is outstanding at a time.
// Optional build macro: COUNT_JOB_TIMEOUT_EN adds a RUN watchdog and res_err.
//
// state  | meaning
// IDLE   | waiting for a word to become visible in the FIFO
// ISSUE  | start pulse to the counter, head word popped, tag latched
// RUN    | counter working; wait for busy to have been seen, then done
// SETTLE | let cnt_bit_count settle before sampling it
// RESULT | result presented until the consumer accepts it
module count_job_sequencer #(
    parameter int word_size     = 32,
    parameter int counter_size  = 6,
    parameter int fifo_depth    = 4,
    parameter int tag_size      = 4,
    parameter int settle_cycles = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [word_size-1:0]          in_data,
    output logic [word_size-1:0]          cnt_data,
    output logic                          cnt_start,
    input  logic                          cnt_busy,
    input  logic                          cnt_done,
    input  logic [counter_size-1:0]       cnt_bit_count,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [counter_size-1:0]       res_count,
    output logic [tag_size-1:0]           res_tag,
`ifdef COUNT_JOB_TIMEOUT_EN
    output logic                          res_err,
`endif
    output logic [$clog2(fifo_depth):0]   fifo_level
);

    localparam int ptr_w    = $clog2(fifo_depth);
    localparam int lvl_w    = ptr_w + 1;
    localparam int settle_w = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, RUN, SETTLE, RESULT} state_t;

    state_t state, state_nxt;

    logic [word_size-1:0] fifo_data [fifo_depth];
    logic [tag_size-1:0]  fifo_tag  [fifo_depth];
    logic [ptr_w-1:0]     wr_ptr, rd_ptr;
    logic [tag_size-1:0]  issue_tag;
    logic                 push, pop;
    logic                 busy_seen;
    logic [settle_w-1:0]  settle_cnt;
    logic                 run_exit, settle_done, wd_expired;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign in_ready    = (fifo_level != lvl_w'(fifo_depth));
    assign push        = in_valid && in_ready;
    assign pop         = (state == ISSUE);
    // A done level without busy having been seen is left over from the previous job.
    assign run_exit    = busy_seen && !cnt_busy && cnt_done;
    assign settle_done = (settle_cnt == '0);

`ifdef COUNT_JOB_TIMEOUT_EN
    localparam int wd_w = $clog2(word_size + 8);
    logic [wd_w-1:0] wd_cnt;
    assign wd_expired = (wd_cnt == '0);
`else
    assign wd_expired = 1'b0;
`endif

    // FIFO storage; contents are qualified by the level, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= in_data;
            fifo_tag[wr_ptr]  <= issue_tag;
        end
    end

    // FIFO pointers, occupancy and the acceptance-order tag counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            issue_tag  <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                issue_tag <= issue_tag + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        cnt_start = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_start = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (run_exit) begin
                    state_nxt = SETTLE;
                end else if (wd_expired) begin
                    state_nxt = RESULT;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job datapath: issued word, busy tracking, settle timer and captured result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_data   <= '0;
            res_count  <= '0;
            res_tag    <= '0;
            busy_seen  <= 1'b0;
            settle_cnt <= '0;
`ifdef COUNT_JOB_TIMEOUT_EN
            wd_cnt     <= '0;
            res_err    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && state_nxt == ISSUE) begin
                cnt_data <= fifo_data[rd_ptr];
            end
            if (state == ISSUE) begin
                res_tag   <= fifo_tag[rd_ptr];
                busy_seen <= 1'b0;
            end else if (state == RUN && cnt_busy) begin
                busy_seen <= 1'b1;
            end
            if (state == RUN && state_nxt == SETTLE) begin
                settle_cnt <= settle_w'(settle_cycles - 1);
            end else if (state == SETTLE && !settle_done) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (state == SETTLE && settle_done) begin
                res_count <= cnt_bit_count;
            end
`ifdef COUNT_JOB_TIMEOUT_EN
            if (state == ISSUE) begin
                wd_cnt  <= wd_w'(word_size + 7);
                res_err <= 1'b0;
            end else if (state == RUN && !wd_expired) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (state == RUN && !run_exit && wd_expired) begin
                res_count <= '0;
                res_err   <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_count_job_sequencer.sv
// tb_count_job_sequencer: directed, table-driven bench for count_job_sequencer
// with a behavioural max-consecutive-ones counter as the downstream responder.
module tb_count_job_sequencer;
    localparam int word_size     = 32;
    localparam int counter_size  = 6;
    localparam int fifo_depth    = 4;
    localparam int tag_size      = 4;
    localparam int settle_cycles = 2;
    localparam int busy_len      = 3;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         in_valid;
    logic                         in_ready;
    logic [word_size-1:0]         in_data;
    logic [word_size-1:0]         cnt_data;
    logic                         cnt_start;
    logic                         cnt_busy;
    logic                         cnt_done;
    logic [counter_size-1:0]      cnt_bit_count;
    logic                         res_valid;
    logic                         res_ready;
    logic [counter_size-1:0]      res_count;
    logic [tag_size-1:0]          res_tag;
`ifdef COUNT_JOB_TIMEOUT_EN
    logic                         res_err;
`endif
    logic [$clog2(fifo_depth):0]  fifo_level;

    always #5 clk = ~clk;

    count_job_sequencer #(
        .word_size(word_size), .counter_size(counter_size), .fifo_depth(fifo_depth),
        .tag_size(tag_size), .settle_cycles(settle_cycles)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cnt_data(cnt_data), .cnt_start(cnt_start), .cnt_busy(cnt_busy),
        .cnt_done(cnt_done), .cnt_bit_count(cnt_bit_count),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_tag(res_tag),
`ifdef COUNT_JOB_TIMEOUT_EN
        .res_err(res_err),
`endif
        .fifo_level(fifo_level)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [counter_size-1:0] max_ones(input logic [word_size-1:0] w);
        int run = 0;
        int best = 0;
        for (int i = 0; i < word_size; i++) begin
            if (w[i]) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        return counter_size'(best);
    endfunction

    // Counter model: busy the cycle after start for busy_len cycles, then done held;
    // bit_count shows garbage for one cycle after done before becoming correct.
    logic                    m_busy, m_done, m_fix, tie_busy_zero;
    logic [counter_size-1:0] m_cnt;
    logic [word_size-1:0]    m_word;
    int                      m_left;
    assign cnt_busy      = m_busy;
    assign cnt_done      = m_done;
    assign cnt_bit_count = m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_fix <= 1'b0;
            m_cnt <= '0; m_left <= 0; m_word <= '0;
        end else if (cnt_start) begin
            m_busy <= !tie_busy_zero; m_done <= 1'b0; m_fix <= 1'b0;
            m_left <= busy_len - 1; m_word <= cnt_data;
        end else if (m_busy) begin
            if (m_left == 0) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_cnt <= '1; m_fix <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (m_fix) begin
            m_cnt <= max_ones(m_word);
            m_fix <= 1'b0;
        end
    end

    // Activity monitor on the falling edge.
    int starts = 0;
    int overlaps = 0;
    int rv_count = 0;
    logic [word_size-1:0] last_start_data = '0;
    always @(negedge clk) begin
        if (cnt_start) begin
            starts++;
            last_start_data = cnt_data;
            if (res_valid) overlaps++;
        end
        if (res_valid) rv_count++;
    end

    typedef struct {
        logic [word_size-1:0]    data;
        logic [counter_size-1:0] count;
        logic [tag_size-1:0]     tag;
    } vec_t;

    vec_t vb[3];
    vec_t vc[6];

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [word_size-1:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL push_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL result_timeout: res_valid stayed 0, expected 1 within 300 cycles");
        end
    endtask

    initial begin
        bit ok;
        int lat;
        int sb;
        int rb;
        logic [counter_size-1:0] hold_cnt;
        logic [tag_size-1:0]     hold_tag;
        bit stable;

        vb[0] = '{32'hFFFF_FFFF, 6'd32, 4'd0};
        vb[1] = '{32'h0000_0000, 6'd0,  4'd1};
        vb[2] = '{32'h0000_000B, 6'd2,  4'd2};

        vc[0] = '{32'h0000_0001, 6'd1,  4'd0};
        vc[1] = '{32'h0000_0003, 6'd2,  4'd1};
        vc[2] = '{32'h0000_0007, 6'd3,  4'd2};
        vc[3] = '{32'hF0F0_FF00, 6'd8,  4'd3};
        vc[4] = '{32'h8000_0001, 6'd1,  4'd4};
        vc[5] = '{32'h00FF_FF00, 6'd16, 4'd5};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        res_ready = 1'b1;
        tie_busy_zero = 1'b0;

        // Reset state
        do_reset();
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_cnt_start",  64'(cnt_start),  64'd0);
        check("rst_cnt_data",   64'(cnt_data),   64'd0);
        check("rst_res_valid",  64'(res_valid),  64'd0);
        check("rst_res_count",  64'(res_count),  64'd0);
        check("rst_res_tag",    64'(res_tag),    64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);

        // Single job: latency 1 + 1 + (busy_len + 1) + settle_cycles
        sb = starts;
        push(32'h0000_00F0);
        wait_result(ok, lat);
        check("single_latency", 64'(lat), 64'(2 + busy_len + 1 + settle_cycles));
        check("single_count",   64'(res_count), 64'd4);
        check("single_tag",     64'(res_tag),   64'd0);
`ifdef COUNT_JOB_TIMEOUT_EN
        check("single_err",     64'(res_err),   64'd0);
`endif
        repeat (4) @(negedge clk);
        check("single_starts",  64'(starts - sb),    64'd1);
        check("single_data",    64'(last_start_data), 64'h0000_00F0);

        // Back-to-back words, results in order
        do_reset();
        for (int i = 0; i < 3; i++) push(vb[i].data);
        for (int i = 0; i < 3; i++) begin
            wait_result(ok, lat);
            check($sformatf("b2b_count[%0d]", i), 64'(res_count), 64'(vb[i].count));
            check($sformatf("b2b_tag[%0d]", i),   64'(res_tag),   64'(vb[i].tag));
        end
        check("b2b_no_start_while_valid", 64'(overlaps), 64'd0);

        // Output back-pressure fills the FIFO
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(vc[i].data);
        check("bp_level_full", 64'(fifo_level), 64'd4);
        check("bp_in_ready",   64'(in_ready),   64'd0);
        in_valid = 1'b1;
        in_data  = vc[5].data;
        wait_result(ok, lat);
        hold_cnt = res_count;
        hold_tag = res_tag;
        sb = starts;
        stable = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (res_count !== hold_cnt || res_tag !== hold_tag || res_valid !== 1'b1 || fifo_level != 4)
                stable = 1'b0;
        end
        check("bp_hold_stable", 64'(stable), 64'd1);
        check("bp_no_issue",    64'(starts - sb), 64'd0);
        fork
            push(vc[5].data);
            begin
                res_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (i > 0) wait_result(ok, lat);
                    check($sformatf("bp_count[%0d]", i), 64'(res_count), 64'(vc[i].count));
                    check($sformatf("bp_tag[%0d]", i),   64'(res_tag),   64'(vc[i].tag));
                end
            end
        join
        check("bp_no_start_while_valid", 64'(overlaps), 64'd0);

        // Tag wrap over 17 jobs
        do_reset();
        fork
            for (int i = 0; i < 17; i++) push(32'hFFFF_FFFF >> (31 - i));
            for (int i = 0; i < 17; i++) begin
                wait_result(ok, lat);
                check($sformatf("wrap_count[%0d]", i), 64'(res_count), 64'(i + 1));
                check($sformatf("wrap_tag[%0d]", i),   64'(res_tag),   64'(i % 16));
            end
        join

        // Reset during RUN abandons the job
        do_reset();
        push(32'h0000_000F);
        push(32'h0000_0003);
        lat = 0;
        while (!cnt_busy && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("mid_reached_run", 64'(cnt_busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_cnt_data",   64'(cnt_data),   64'd0);
        check("mid_fifo_level", 64'(fifo_level), 64'd0);
        check("mid_in_ready",   64'(in_ready),   64'd1);
        check("mid_res_valid",  64'(res_valid),  64'd0);
        check("mid_res_count",  64'(res_count),  64'd0);
        check("mid_cnt_start",  64'(cnt_start),  64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb = starts;
        rb = rv_count;
        repeat (60) @(negedge clk);
        check("mid_no_result", 64'(rv_count - rb), 64'd0);
        check("mid_no_start",  64'(starts - sb),   64'd0);

`ifdef COUNT_JOB_TIMEOUT_EN
        // Watchdog: counter never raises busy
        do_reset();
        tie_busy_zero = 1'b1;
        push(32'h0000_00FF);
        wait_result(ok, lat);
        check("wd_latency", 64'(lat), 64'(2 + word_size + 8));
        check("wd_err",     64'(res_err),   64'd1);
        check("wd_count",   64'(res_count), 64'd0);
        tie_busy_zero = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/count_job_sequencer.md
Name: count_job_sequencer

Overview:
- Upstream feeder for the max-consecutive-ones counter.
- Buffers incoming words in a small FIFO and issues them one at a time on the counter's data/start interface.
- Tracks the counter's busy/done handshake, captures bit_count once it is stable, and presents it as a tagged result on a valid/ready output.
- Only one job is outstanding at a time.

Parameters:
- word_size, 32: width of input words and cnt_data.
- counter_size, 6: width of cnt_bit_count and res_count.
- fifo_depth, 4: input FIFO entries; must be a power of 2, at least 2.
- tag_size, 4: width of the job sequence tag.
- settle_cycles, 2: cycles waited after done rises before bit_count is sampled; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  an input word is offered.
- in_ready  out  1  FIFO can accept a word (not full).
- in_data  in  word_size  word to analyse.
- cnt_data  out  word_size  word driven to the counter, registered.
- cnt_start  out  1  one-cycle start pulse to the counter.
- cnt_busy  in  1  counter busy.
- cnt_done  in  1  counter done (level; held until the next start).
- cnt_bit_count  in  counter_size  counter result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_count  out  counter_size  captured maximum run length.
- res_tag  out  tag_size  sequence number of the word, in acceptance order.
- fifo_level  out  clog2(fifo_depth)+1  current FIFO occupancy.

Behaviour:
- Reset (async): FIFO empty, fifo_level=0, in_ready=1, cnt_start=0, cnt_data=0, res_valid=0, res_count=0, res_tag=0, issue tag counter=0, FSM=IDLE.
- Reset mid-job abandons the job; nothing is emitted afterwards.
- FIFO push: on in_valid && in_ready, the word is written together with the current tag; the tag then increments and wraps modulo 2^tag_size.
- in_ready=0 whenever the FIFO is full, even if a pop occurs in the same cycle (no full-bypass).
- No empty-bypass: a pushed word is visible to the FSM the following cycle.
- A simultaneous push and pop when not full leaves fifo_level unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, go to ISSUE; cnt_data is loaded with the head word on this transition.
  - ISSUE: cnt_start=1 for exactly one cycle; cnt_data is held stable; head is popped; its tag is latched; clear busy_seen; go to RUN.
  - RUN: set busy_seen when cnt_busy=1. Go to SETTLE only when busy_seen=1, cnt_busy=0 and cnt_done=1. This rejects the stale done level from the previous job. The counter raises busy the cycle after start.
  - SETTLE: count settle_cycles cycles, then sample cnt_bit_count into res_count and go to RESULT.
  - RESULT: res_valid=1; res_count and res_tag are held stable until res_valid && res_ready, then go to IDLE.
- The next word is never issued while a result is pending, so output back-pressure stalls the FIFO.
- cnt_data keeps its last value outside ISSUE. cnt_start=0 in every state except ISSUE.
- Minimum latency from push into an empty FIFO to res_valid: 1 (visible) + 1 (ISSUE) + run + settle_cycles. Here run is counter busy cycles plus 1.
- Minimum issue-to-issue spacing is 4 + settle_cycles + busy cycles when res_ready is held high.
- Tag wrap: the job after tag 2^tag_size-1 carries tag 0.

Optional Feature:
- Macro: COUNT_JOB_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles in RUN.
  - If RUN lasts word_size+8 cycles without the exit condition, go directly to RESULT with res_count=0 and res_err=1.
  - res_err is an extra 1-bit output, valid with res_valid and 0 for normal results; reset value 0.
- When undefined: no res_err port, and RUN waits indefinitely.

Test Plan:
- After reset, push 0x000000F0 and hold res_ready=1: exactly one cnt_start pulse with cnt_data=0x000000F0; then res_valid with res_count=4, res_tag=0.
- Push 0xFFFFFFFF, 0x00000000, 0x0000000B back-to-back: results arrive in order as (32,tag0), (0,tag1), (2,tag2); cnt_start never pulses while res_valid=1.
- Hold res_ready=0 and push 6 words with depth 4: in_ready drops once fifo_level=4 (the first word has already been popped), and res_count/res_tag stay stable while stalled. Releasing res_ready drains all 6 results in order.
- Push 17 words with tag_size=4: the 17th result carries res_tag=0.
- Assert reset during RUN: all outputs return to reset values asynchronously, fifo_level=0, and no result is emitted for the abandoned job.
- With COUNT_JOB_TIMEOUT_EN, tie cnt_busy=0: after word_size+8 RUN cycles, res_valid=1, res_err=1, res_count=0.
